// File: rtl/trex_collision_pkg.sv
// Shared types and constants for the trex collision scanner.
// Optional sub-box refinement is enabled by defining COLLISION_FINE_EN.
package trex_collision_pkg;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [10:0] w;
        logic [10:0] h;
    } box_t;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        FIN
`ifdef COLLISION_FINE_EN
        , FINE
`endif
    } state_t;

    localparam logic [2:0]  DUCKING0 = 3'd5;
    localparam logic [2:0]  DUCKING1 = 3'd6;

    localparam logic [10:0] RUN_W   = 11'd44;
    localparam logic [10:0] RUN_H   = 11'd47;
    localparam logic [10:0] DUCK_W  = 11'd59;
    localparam logic [10:0] DUCK_H  = 11'd25;
    localparam logic [10:0] DUCK_DY = 11'd22;

    // Sub-box x/y are offsets from the inset box; w/h are absolute.
    localparam box_t HEAD_OFS = '{x: 11'd22, y: 11'd0,  w: 11'd17, h: 11'd16};
    localparam box_t BODY_OFS = '{x: 11'd0,  y: 11'd16, w: 11'd30, h: 11'd15};
    localparam box_t LEGS_OFS = '{x: 11'd8,  y: 11'd31, w: 11'd14, h: 11'd14};

    function automatic logic is_ducking(input logic [2:0] frame);
        return (frame == DUCKING0) || (frame == DUCKING1);
    endfunction

    function automatic box_t trex_box(input logic [9:0] x, input logic [9:0] y,
                                      input logic [2:0] frame, input int unsigned inset);
        box_t b;
        logic duck;
        duck = is_ducking(frame);
        b.x = 11'(x) + 11'(inset);
        b.y = 11'(y) + (duck ? DUCK_DY : 11'd0) + 11'(inset);
        b.w = (duck ? DUCK_W : RUN_W) - 11'(2 * inset);
        b.h = (duck ? DUCK_H : RUN_H) - 11'(2 * inset);
        return b;
    endfunction

    function automatic box_t sub_box(input box_t base, input box_t ofs);
        box_t b;
        b.x = base.x + ofs.x;
        b.y = base.y + ofs.y;
        b.w = ofs.w;
        b.h = ofs.h;
        return b;
    endfunction

endpackage

// File: rtl/trex_collision_box_overlap.sv
// Strict axis-aligned overlap test between two boxes; touching edges do not overlap.
module box_overlap
    import trex_collision_pkg::*;
(
    input  box_t a,
    input  box_t b,
    output logic hit
);

    always_comb begin
        hit = (a.x < b.x + b.w) && (b.x < a.x + a.w) &&
              (a.y < b.y + b.h) && (b.y < a.y + a.h);
    end

endmodule

// File: rtl/trex_collision.sv
// Per-frame obstacle scan with sticky crash flag; one slot issued per cycle,
// compared the cycle after. Define COLLISION_FINE_EN for the sub-box second pass.
module trex_collision
    import trex_collision_pkg::*;
#(
    parameter int unsigned MAX_OBS = 3,
    parameter int unsigned INSET   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       tick,
    input  logic [9:0] trex_x,
    input  logic [9:0] trex_y,
    input  logic [2:0] trex_frame,
    output logic       obs_rd,
    output logic [2:0] obs_idx,
    input  logic       obs_valid,
    input  logic [9:0] obs_x,
    input  logic [9:0] obs_y,
    input  logic [6:0] obs_w,
    input  logic [6:0] obs_h,
    output logic       busy,
    output logic       done,
    output logic       crash,
    output logic [2:0] hit_idx
);

    localparam logic [2:0] LAST = 3'(MAX_OBS - 1);

    state_t     state;
    box_t       tbox;
    box_t       obox;
    logic       pend;
    logic [2:0] pend_idx;
    logic       box_hit;
    logic       cand;

    assign obox = '{x: 11'(obs_x), y: 11'(obs_y), w: 11'(obs_w), h: 11'(obs_h)};
    assign cand = pend && obs_valid && box_hit;

    box_overlap u_box (.a(tbox), .b(obox), .hit(box_hit));

`ifdef COLLISION_FINE_EN
    box_t       cbox;
    logic [2:0] cand_idx;
    logic       duck;
    logic       head_hit, body_hit, legs_hit;
    logic       fine_hit;

    box_overlap u_head (.a(sub_box(tbox, HEAD_OFS)), .b(cbox), .hit(head_hit));
    box_overlap u_body (.a(sub_box(tbox, BODY_OFS)), .b(cbox), .hit(body_hit));
    box_overlap u_legs (.a(sub_box(tbox, LEGS_OFS)), .b(cbox), .hit(legs_hit));

    // Ducking uses the full box, which the candidate already overlaps.
    assign fine_hit = duck || head_hit || body_hit || legs_hit;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            tbox     <= '0;
            pend     <= 1'b0;
            pend_idx <= '0;
            obs_rd   <= 1'b0;
            obs_idx  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            crash    <= 1'b0;
            hit_idx  <= '0;
`ifdef COLLISION_FINE_EN
            cbox     <= '0;
            cand_idx <= '0;
            duck     <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            pend     <= obs_rd;
            pend_idx <= obs_idx;
            case (state)
                IDLE: begin
                    if (tick && enable && !crash) begin
                        tbox    <= trex_box(trex_x, trex_y, trex_frame, INSET);
`ifdef COLLISION_FINE_EN
                        duck    <= is_ducking(trex_frame);
`endif
                        state   <= SCAN;
                        obs_rd  <= 1'b1;
                        obs_idx <= '0;
                        busy    <= 1'b1;
                    end
                end
                SCAN, DRAIN: begin
                    if (cand) begin
                        obs_rd  <= 1'b0;
`ifdef COLLISION_FINE_EN
                        cbox     <= obox;
                        cand_idx <= pend_idx;
                        state    <= FINE;
`else
                        crash   <= 1'b1;
                        hit_idx <= pend_idx;
                        done    <= 1'b1;
                        state   <= FIN;
`endif
                    end else if (state == DRAIN) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else if (obs_idx == LAST) begin
                        obs_rd <= 1'b0;
                        state  <= DRAIN;
                    end else begin
                        obs_idx <= obs_idx + 3'd1;
                    end
                end
`ifdef COLLISION_FINE_EN
                // A rejected candidate discards the in-flight read and re-issues the next slot.
                FINE: begin
                    if (fine_hit) begin
                        crash   <= 1'b1;
                        hit_idx <= cand_idx;
                        done    <= 1'b1;
                        state   <= FIN;
                    end else if (cand_idx == LAST) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        obs_rd  <= 1'b1;
                        obs_idx <= cand_idx + 3'd1;
                        state   <= SCAN;
                    end
                end
`endif
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trex_collision.sv
// Directed bench for trex_collision (default build, MAX_OBS=3, INSET=1)
// with a registered-read obstacle table model.
module tb_trex_collision;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b1;
    logic       tick = 1'b0;
    logic [9:0] trex_x = 10'd50;
    logic [9:0] trex_y = 10'd93;
    logic [2:0] trex_frame = 3'd2;
    logic       obs_rd;
    logic [2:0] obs_idx;
    logic       obs_valid = 1'b0;
    logic [9:0] obs_x = '0, obs_y = '0;
    logic [6:0] obs_w = '0, obs_h = '0;
    logic       busy, done, crash;
    logic [2:0] hit_idx;

    logic       tv [8];
    logic [9:0] tx [8];
    logic [9:0] ty [8];
    logic [6:0] tw [8];
    logic [6:0] th [8];

    int n_cmp = 0;
    int n_bad = 0;

    trex_collision #(.MAX_OBS(3), .INSET(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .tick(tick),
        .trex_x(trex_x), .trex_y(trex_y), .trex_frame(trex_frame),
        .obs_rd(obs_rd), .obs_idx(obs_idx), .obs_valid(obs_valid),
        .obs_x(obs_x), .obs_y(obs_y), .obs_w(obs_w), .obs_h(obs_h),
        .busy(busy), .done(done), .crash(crash), .hit_idx(hit_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (obs_rd) begin
            obs_valid <= tv[obs_idx];
            obs_x     <= tx[obs_idx];
            obs_y     <= ty[obs_idx];
            obs_w     <= tw[obs_idx];
            obs_h     <= th[obs_idx];
        end else begin
            obs_valid <= 1'b0;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_table();
        for (int i = 0; i < 8; i++) begin
            tv[i] = 1'b0; tx[i] = '0; ty[i] = '0; tw[i] = '0; th[i] = '0;
        end
    endtask

    task automatic set_slot(input int s, input int x, input int y, input int w, input int h);
        tv[s] = 1'b1; tx[s] = 10'(x); ty[s] = 10'(y); tw[s] = 7'(w); th[s] = 7'(h);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
    endtask

    // Tick at cycle 0; returns the cycle in which done is seen (-1 on timeout)
    // and the cycle-1 outputs. extra_at>0 pulses tick again during that cycle.
    task automatic run_scan(input int extra_at, output int done_cyc,
                            output int rd1, output int idx1, output int busy1);
        int cyc;
        done_cyc = -1;
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        cyc = 1;
        rd1 = int'(obs_rd); idx1 = int'(obs_idx); busy1 = int'(busy);
        while (cyc < 20) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            tick = (cyc + 1 == extra_at);
            @(posedge clk); #1;
            cyc++;
        end
        tick = 1'b0;
    endtask

    task automatic watch_quiet(input string tag, input int n);
        int act = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (obs_rd || done) act++;
        end
        chk(tag, act, 0);
    endtask

    initial begin
        int dc, rd1, idx1, b1;
        clear_table();
        do_reset();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_crash", crash, 0);
        chk("rst_hit_idx", hit_idx, 0);
        chk("rst_obs_rd", obs_rd, 0);
        chk("rst_obs_idx", obs_idx, 0);
        rst = 1'b1;

        // No hit: obstacle entirely right of box (right edge 93)
        set_slot(0, 100, 110, 17, 35);
        run_scan(0, dc, rd1, idx1, b1);
        chk("nohit_done_cyc", dc, 5);
        chk("nohit_crash", crash, 0);
        chk("nohit_rd1", rd1, 1);
        chk("nohit_idx1", idx1, 0);
        chk("nohit_busy1", b1, 1);
        chk("nohit_busy_done", busy, 1);
        @(posedge clk); #1;
        chk("nohit_busy_after", busy, 0);

        // Edge abutment: ox = 51 + 42 is a touch, not an overlap
        clear_table();
        set_slot(0, 93, 110, 17, 35);
        run_scan(0, dc, rd1, idx1, b1);
        chk("abut93_done_cyc", dc, 5);
        chk("abut93_crash", crash, 0);

        // Ducking box top 116 clears the bird bottom 110
        clear_table();
        set_slot(0, 60, 90, 46, 20);
        trex_frame = 3'd5;
        run_scan(0, dc, rd1, idx1, b1);
        chk("duck_done_cyc", dc, 5);
        chk("duck_crash", crash, 0);
        trex_frame = 3'd2;

        // Ignored ticks: enable low, then a tick while busy
        clear_table();
        enable = 1'b0;
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        watch_quiet("tick_disabled", 8);
        enable = 1'b1;
        run_scan(2, dc, rd1, idx1, b1);
        chk("busytick_done_cyc", dc, 5);
        watch_quiet("tick_busy", 8);

        // Reset in cycle 2 of a scan
        set_slot(2, 60, 100, 20, 20);
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_crash", crash, 0);
        chk("midrst_obs_rd", obs_rd, 0);
        rst = 1'b1;
        clear_table();
        run_scan(0, dc, rd1, idx1, b1);
        chk("restart_rd1", rd1, 1);
        chk("restart_idx1", idx1, 0);
        chk("restart_done_cyc", dc, 5);

        // Cactus hit in slot 1; slot 2 would also hit but must not be reported
        clear_table();
        set_slot(0, 100, 110, 17, 35);
        set_slot(1, 90, 110, 17, 35);
        set_slot(2, 60, 100, 20, 20);
        run_scan(0, dc, rd1, idx1, b1);
        chk("cactus_done_cyc", dc, 4);
        chk("cactus_crash", crash, 1);
        chk("cactus_hit_idx", hit_idx, 1);
        chk("cactus_obs_rd", obs_rd, 0);

        // Crash is sticky and blocks further scans
        watch_quiet("tick_after_crash_pre", 2);
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        watch_quiet("tick_after_crash", 8);
        chk("crash_sticky", crash, 1);

        // Running trex vs bird in slot 0
        do_reset();
        clear_table();
        set_slot(0, 60, 90, 46, 20);
        run_scan(0, dc, rd1, idx1, b1);
        chk("bird_done_cyc", dc, 3);
        chk("bird_crash", crash, 1);
        chk("bird_hit_idx", hit_idx, 0);

        // Edge: ox = 92 overlaps by one pixel, in the last slot
        do_reset();
        chk("rst2_crash", crash, 0);
        clear_table();
        set_slot(2, 92, 110, 17, 35);
        run_scan(0, dc, rd1, idx1, b1);
        chk("abut92_done_cyc", dc, 5);
        chk("abut92_crash", crash, 1);
        chk("abut92_hit_idx", hit_idx, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trex_collision.md
Name: trex_collision

Overview:
- Downstream of the trex character block: consumes its x_pos/y_pos/frame once per game frame and scans the obstacle table for an overlap.
- On overlap it raises a sticky crash flag, which the top level feeds back into the trex crash input.
- Sequential scan over a registered-read obstacle table, one obstacle per cycle (pipelined), early exit on first hit.

Parameters:
- MAX_OBS, 3, number of obstacle table slots scanned (1..8).
- INSET, 1, pixels the trex box is shrunk on every side before comparison.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low (asserted when 0)
- enable  in  1  game running; ticks are ignored while 0
- tick  in  1  one-cycle pulse at start of each game frame
- trex_x  in  10  trex x_pos
- trex_y  in  10  trex y_pos
- trex_frame  in  3  trex frame code
- obs_rd  out  1  table read strobe
- obs_idx  out  3  table slot address
- obs_valid  in  1  slot occupied (valid the cycle after obs_rd)
- obs_x  in  10  obstacle left edge (same timing)
- obs_y  in  10  obstacle top edge
- obs_w  in  7  obstacle width
- obs_h  in  7  obstacle height
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse, scan finished
- crash  out  1  sticky collision flag
- hit_idx  out  3  slot that caused the crash

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE, busy=0, done=0, crash=0, hit_idx=0, obs_rd=0, obs_idx=0. Reset mid-scan aborts the scan immediately with no done pulse.
- FSM states: IDLE, SCAN, DRAIN, FIN.
- IDLE, tick=1, enable=1, crash=0:
  - Latch the trex box.
  - Go to SCAN with obs_idx=0 and obs_rd=1.
- Ticks in any other state, or with enable=0 or crash=1, are ignored.
- Trex box selection:
  - Frames 5,6 (ducking): width 59, height 25, top = trex_y+22.
  - All other frames: width 44, height 47, top = trex_y.
  - INSET is then applied: left += INSET, top += INSET, width −= 2·INSET, height −= 2·INSET.
- All box arithmetic is 11-bit unsigned (no wrap).
- SCAN:
  - Slot k is issued in cycle k+1 after the tick.
  - Its data is compared in cycle k+2, overlapping with the issue of slot k+1.
  - After issuing slot MAX_OBS−1, go to DRAIN with obs_rd=0.
- DRAIN: compares the last slot, then goes to FIN.
- Overlap rule (strict), evaluated only when obs_valid=1:
  - tl < ox+ow, ox < tl+tw, tt < oy+oh, and oy < tt+th.
- On the first overlap:
  - crash←1 and hit_idx←slot, both visible the next cycle.
  - obs_rd drops and any outstanding data is discarded.
  - Go directly to FIN.
- FIN: done=1 for one cycle, busy=0 next, return to IDLE.
- Latency without a hit: tick at cycle 0, done and final crash value at cycle MAX_OBS+2.
- busy=1 from cycle 1 through the done cycle inclusive.
- crash is cleared only by reset.

Optional Feature:
- COLLISION_FINE_EN defined:
  - After a box hit, run a second check against trex sub-boxes before declaring a crash.
  - Non-ducking sub-boxes (offsets from the inset box): head (22,0,17,16), body (0,16,30,15), legs (8,31,14,14).
  - Ducking: single full box.
  - Sub-box checks add one cycle per candidate hit.
  - A crash is declared only if a sub-box overlaps; otherwise the scan continues with the next slot.
- Undefined: the bounding-box overlap alone is decisive.

Decomposition:
- Package trex_collision_pkg holds:
  - Box typedef struct {x, y, w, h} in 11 bits.
  - Scan FSM enum.
  - Ducking/normal dimensions and the duck y-offset 22.
  - Sub-box constants.
  - Frame codes, identical values to the trex package: DUCKING0=5, DUCKING1=6.
- Sub-module box_overlap: purely combinational, two box structs in, overlap bit out. Instantiated once, or four times with COLLISION_FINE_EN.

Test Plan:
- No-hit scan:
  - Stimulus: MAX_OBS=3, trex (50,93) frame 2; single obstacle slot 0 at (100,110,17,35); slots 1,2 invalid.
  - Required: done at cycle 5, crash=0.
- Cactus hit:
  - Stimulus: same trex; slot 1 at (90,110,17,35).
  - Required: crash=1, hit_idx=1; done in the cycle after the slot-1 compare; slot 2 never compared.
- Duck vs bird:
  - Stimulus: bird at (60,90,46,20), trex frame 2 (running).
  - Required: crash=1.
  - Stimulus: same bird, frame 5 (ducking, box top 116).
  - Required: crash=0.
- Edge abutment:
  - Stimulus: obstacle ox=93 (= inset left 51 + width 42), running.
  - Required: no hit.
  - Stimulus: ox=92.
  - Required: hit.
- Ignored ticks:
  - Stimulus: tick during busy; tick with enable=0; tick after crash.
  - Required: obs_rd stays 0, no done pulse.
- Reset mid-scan:
  - Stimulus: rst=0 in cycle 2 of a scan.
  - Required: next cycle busy=0, done=0, crash=0, obs_rd=0; a new tick restarts the scan at slot 0.
